// File: rtl/regfile_pkg.sv
// Shared defaults and constants for the multi-port register file.
//   DEF_DW / DEF_AW / DEF_NRD / DEF_BYPASS : default parameter values
//   ZERO_REG                               : hard-wired zero register address
//   num_regs()                             : register count for an address width
package regfile_pkg;

    localparam int DEF_DW     = 32;
    localparam int DEF_AW     = 5;
    localparam int DEF_NRD    = 2;
    localparam int DEF_BYPASS = 1;

    localparam int ZERO_REG   = 0;

    function automatic int num_regs(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for the register file.
// A register is marked busy by a reserve (rsv/rsvn) and released by a late
// write (we1/wn1). nbusy is a registered population count maintained
// incrementally from the net change of the busy vector.
//
// Ports:
//   clk, clrn        : clock, asynchronous active-low reset
//   rn   [NRD*AW]    : read addresses (port k at [k*AW +: AW])
//   qbusy[NRD]       : registered busy bit of each read address
//   we1, wn1         : late write enable/address (clears busy)
//   rsv, rsvn        : reserve enable/address (sets busy)
//   nbusy[AW+1]      : number of busy registers
//
// Control semantics: every input is a single-cycle strobe sampled on the
// rising edge; there is no backpressure, so an enable high at an edge is
// always accepted (no valid/ready pairing is needed).
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int AW  = DEF_AW,
    parameter int NRD = DEF_NRD
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [NRD*AW-1:0] rn,
    output logic [NRD-1:0]    qbusy,
    input  logic              we1,
    input  logic [AW-1:0]     wn1,
    input  logic              rsv,
    input  logic [AW-1:0]     rsvn,
    output logic [AW:0]       nbusy
);

    localparam int NREG = num_regs(AW);
    localparam int CW   = AW + 1;

    logic [NREG-1:0] busy_q, busy_d;
    logic [CW-1:0]   nbusy_q, nbusy_d;

    logic set_ok, clr_ok, set_new, clr_real;

    always_comb begin
        // Register 0 can never become busy, so both strobes ignore it.
        set_ok   = rsv && (rsvn != AW'(ZERO_REG));
        clr_ok   = we1 && (wn1 != AW'(ZERO_REG));

        busy_d   = busy_q;
        if (clr_ok) busy_d[wn1]  = 1'b0;
        // Applied after the clear so a same-register reserve wins.
        if (set_ok) busy_d[rsvn] = 1'b1;

        // Count only real transitions: re-reserving a busy register or
        // releasing a free one leaves the population unchanged.
        set_new  = set_ok && !busy_q[rsvn];
        clr_real = clr_ok && busy_q[wn1] && !(set_ok && (rsvn == wn1));

        nbusy_d  = nbusy_q + CW'(set_new) - CW'(clr_real);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            busy_q  <= '0;
            nbusy_q <= '0;
        end else begin
            busy_q  <= busy_d;
            nbusy_q <= nbusy_d;
        end
    end

    // Busy flags come straight from the flops; no same-cycle forwarding.
    always_comb begin
        qbusy = '0;
        for (int k = 0; k < NRD; k++) begin
            qbusy[k] = busy_q[rn[k*AW +: AW]];
        end
    end

    assign nbusy = nbusy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports and a busy scoreboard.
// Register 0 reads as zero and is never written. Reads are combinational;
// with BYPASS=1 they see the data being written in the same cycle.
//
// Ports:
//   clk, clrn        : clock, asynchronous active-low reset
//   rn [NRD*AW]      : read addresses (port k at [k*AW +: AW])
//   q  [NRD*DW]      : read data      (port k at [k*DW +: DW])
//   qbusy[NRD]       : busy flag of each read address
//   we0, wn0, d0     : primary (ALU) write port
//   we1, wn1, d1     : late (load/multicycle) write port, releases busy
//   rsv, rsvn        : reserve request, marks rsvn busy
//   nbusy[AW+1]      : number of busy registers
//
// Control semantics: every enable is a single-cycle strobe sampled on the
// rising edge with no backpressure; an enable high at an edge always takes.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int AW     = DEF_AW,
    parameter int NRD    = DEF_NRD,
    parameter int BYPASS = DEF_BYPASS
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [NRD*AW-1:0] rn,
    output logic [NRD*DW-1:0] q,
    output logic [NRD-1:0]    qbusy,
    input  logic              we0,
    input  logic [AW-1:0]     wn0,
    input  logic [DW-1:0]     d0,
    input  logic              we1,
    input  logic [AW-1:0]     wn1,
    input  logic [DW-1:0]     d1,
    input  logic              rsv,
    input  logic [AW-1:0]     rsvn,
    output logic [AW:0]       nbusy
);

    localparam int NREG = num_regs(AW);

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];
    logic          wr0_ok, wr1_ok;

    always_comb begin
        wr0_ok = we0 && (wn0 != AW'(ZERO_REG));
        wr1_ok = we1 && (wn1 != AW'(ZERO_REG));

        regs_d = regs_q;
        if (wr1_ok) regs_d[wn1] = d1;
        // Port 0 applied last so it wins when both ports hit one register.
        if (wr0_ok) regs_d[wn0] = d0;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // regs_d is the post-edge view, so reading it gives write-through.
    // Entry 0 is never written in either view, so it always reads zero.
    always_comb begin
        q = '0;
        for (int k = 0; k < NRD; k++) begin
            if (BYPASS != 0) q[k*DW +: DW] = regs_d[rn[k*AW +: AW]];
            else             q[k*DW +: DW] = regs_q[rn[k*AW +: AW]];
        end
    end

    regfile_scoreboard #(
        .AW  (AW),
        .NRD (NRD)
    ) u_scoreboard (
        .clk   (clk),
        .clrn  (clrn),
        .rn    (rn),
        .qbusy (qbusy),
        .we1   (we1),
        .wn1   (wn1),
        .rsv   (rsv),
        .rsvn  (rsvn),
        .nbusy (nbusy)
    );

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data width in bits.
REQ-002 SHALL have parameter AW, default 5, meaning address width; register count 2**AW.
REQ-003 SHALL have parameter NRD, default 2, meaning number of read ports (1..4).
REQ-004 SHALL have parameter BYPASS, default 1, meaning 1 = same-cycle write-through to reads.
REQ-005 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-006 SHALL have port clrn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port rn, input, NRD*AW, read addresses, port k at bits [k*AW +: AW].
REQ-008 SHALL have port q, output, NRD*DW, read data, port k at bits [k*DW +: DW].
REQ-009 SHALL have port qbusy, output, NRD, scoreboard busy flag for each read address.
REQ-010 SHALL have ports we0/wn0/d0, input, 1/AW/DW, primary (ALU) write port.
REQ-011 SHALL have ports we1/wn1/d1, input, 1/AW/DW, late (load/multicycle) write port; a write also clears busy.
REQ-012 SHALL have ports rsv/rsvn, input, 1/AW, reserve request marking register rsvn busy.
REQ-013 SHALL have port nbusy, output, AW+1, count of busy registers.

Function
REQ-014 Register 0 SHALL read as 0, ignore writes, and never be busy.
REQ-015 Reads SHALL be combinational: q[k] = reg[rn[k]] with zero latency.
REQ-016 With BYPASS=1, a read SHALL return the data being written to the same non-zero address in that cycle; port-0 data wins if both ports write it.
REQ-017 With BYPASS=0, a read SHALL return the pre-edge value; new data becomes visible the cycle after the edge.
REQ-018 Writes SHALL commit at the rising clk edge when the enable is 1 and the address is non-zero.
REQ-019 On we0 and we1 to the same address, d0 SHALL be stored; busy SHALL still be cleared by we1.
REQ-020 Busy bit b[r] SHALL set on rsv with rsvn==r, and clear on we1 with wn1==r.
REQ-021 When rsv and we1 target the same register in the same cycle, b[r] SHALL end set (set wins).
REQ-022 A rsv to a register that is already busy SHALL leave it busy; nbusy SHALL NOT double-count it.
REQ-023 A we1 to a register that is not busy SHALL write data and leave busy clear.
REQ-024 qbusy[k] SHALL reflect the registered b[rn[k]] with no bypass from the same-cycle rsv or we1.
REQ-025 nbusy SHALL be a registered counter, updated +1/-1/0 from the net busy-bit change each cycle, and SHALL always equal popcount(b).
REQ-026 we0 SHALL NOT affect busy bits.

Reset
REQ-027 With clrn=0, all registers SHALL be 0, all busy bits 0, and nbusy 0, immediately and independent of clk.
REQ-028 A write or reserve coincident with reset release SHALL be ignored until the first rising edge with clrn=1.
REQ-029 Reset asserted mid-reservation SHALL discard the pending state; no output retains a pre-reset value.

Structure
REQ-030 Package regfile_pkg SHALL hold the default DW/AW/NRD values and the zero-register address constant.
REQ-031 The scoreboard (busy bits plus nbusy counter) SHALL be the sub-module regfile_scoreboard; data storage and read muxing SHALL stay in regfile_mp.

Verification
REQ-032 Reset, then read all 32 addresses -> q=0, qbusy=0, nbusy=0.
REQ-033 we0 wn0=5 d0=0xDEADBEEF with rn0=5 in the same cycle -> BYPASS=1: q0=0xDEADBEEF same cycle; BYPASS=0: old 0, then 0xDEADBEEF next cycle.
REQ-034 we0 wn0=7 d0=0x11 and we1 wn1=7 d1=0x22 in the same cycle, 7 previously reserved -> reg7=0x11, busy7 cleared, nbusy decremented.
REQ-035 rsv rsvn=9, then rsv 9 again, then we1 wn1=9 d1=0x55 -> nbusy 1,1,0; qbusy for 9 = 1,1,0; reg9=0x55.
REQ-036 Same cycle rsv rsvn=3 and we1 wn1=3 (3 busy) -> busy3 stays 1, nbusy unchanged, reg3 updated.
REQ-037 Writes/rsv to address 0, then clrn pulsed low mid-sequence with 4 busy registers -> reg0 stays 0; all state 0 asynchronously.
